alu_share_ctrl: RTL and testbench

//  Shares one 32-bit yAluWeak instance between two requesters (e.g. fetch-PC incrementer and execute stage).

---
 rtl/alu_share_pkg.sv | 23 ++
 rtl/alu_share_ctrl_if.sv | 33 +++
 rtl/rr_arb2.sv | 18 +
 rtl/yAluWeak.sv | 26 ++
 rtl/alu_share_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 289 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU controller: ALU op codes, FSM state
// encoding and the legal-op predicate.
package alu_share_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // 011, 100 and 101 have no ALU meaning and are answered with an error response.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between two requesters and the shared-ALU controller.
//   req_valid/req_ready  per-requester request handshake (bit i = requester i)
//   req{0,1}_a/_b/_op    requester operands and ALU op
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_z/rsp_ex/rsp_err shared response payload, qualified by rsp_valid
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
  parameter int unsigned W = 32
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [2:0]   req0_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req1_op;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_z;
  logic         rsp_ex;
  logic         rsp_err;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_ex, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer register is owned by the parent.
//   req  in  2  request lines
//   ptr  in  1  preferred requester this cycle
//   gnt  out 2  one-hot grant, zero when no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end
endmodule

// File: rtl/yAluWeak.sv
// Reduced 32-bit ALU: AND, OR, ADD, SUB. SLT and undefined ops return 0 and the
// ex flag is never raised.
//   z   out 32  result
//   ex  out 1   exception flag (always 0 in this reduced ALU)
//   a,b in  32  operands
//   op  in  3   operation
module yAluWeak (
  output logic [31:0] z,
  output logic        ex,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op
);
  always_comb begin
    z = 32'h0;
    case (op)
      3'b000:  z = a & b;
      3'b001:  z = a | b;
      3'b010:  z = a + b;
      3'b110:  z = a - b;
      default: z = 32'h0;
    endcase
  end

  assign ex = 1'b0;
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one yAluWeak between two requesters with round-robin arbitration.
// One operation in flight; operands are registered at accept and held at the
// ALU for EXEC_CYCLES clocks before the result is captured.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of alu_share_ctrl_if (request and response handshakes)
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_ctrl_if.slave bus
);

  localparam logic [3:0] LastCnt = 4'(EXEC_CYCLES - 1);

  state_e       state_q;
  logic         ptr_q;
  logic         gnt_id_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] rsp_z_q;
  logic         rsp_ex_q;
  logic         rsp_err_q;
  logic [1:0]   rsp_valid_q;

  logic [1:0]   gnt;
  logic         gnt_id;
  logic         xfer;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_op;
  logic [31:0]  alu_z;
  logic         alu_ex;

  rr_arb2 u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign gnt_id = gnt[1];
  assign sel_a  = gnt_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = gnt_id ? bus.req1_b  : bus.req0_b;
  assign sel_op = gnt_id ? bus.req1_op : bus.req0_op;

  // Ready is only offered while idle, so an accept can never overlap a response.
  assign bus.req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;
  assign xfer          = |(bus.req_valid & bus.req_ready);

  yAluWeak u_alu (
    .z  (alu_z),
    .ex (alu_ex),
    .a  (a_q),
    .b  (b_q),
    .op (op_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_id_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      cnt_q       <= '0;
      rsp_z_q     <= '0;
      rsp_ex_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            op_q     <= sel_op;
            gnt_id_q <= gnt_id;
            ptr_q    <= ~gnt_id;
            cnt_q    <= '0;
            if (op_legal(sel_op)) begin
              state_q <= ST_EXEC;
            end else begin
              // Illegal op bypasses the ALU and answers on the next cycle.
              rsp_z_q     <= '0;
              rsp_ex_q    <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= gnt;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            rsp_z_q     <= W'(alu_z);
            rsp_ex_q    <= alu_ex;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_id_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Only the owner's rsp_ready can complete the response.
          if (bus.rsp_ready[gnt_id_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_ex    = rsp_ex_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic, all
// checked cycle-by-cycle against a transaction-level model with a scoreboard.
module tb_alu_share_ctrl;

  localparam int unsigned EC = 3;

  typedef struct {
    bit        id;
    bit [31:0] z;
    bit        ex;
    bit        err;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_share_ctrl_if #(.W(32)) bus ();

  alu_share_ctrl #(
    .W           (32),
    .EXEC_CYCLES (EC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Model state: one transaction outstanding at most.
  bit   m_busy = 1'b0;
  bit   m_ptr  = 1'b0;
  bit   m_id   = 1'b0;
  int   m_due  = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t ref_op(input bit id, input bit [31:0] a, input bit [31:0] b,
                                  input bit [2:0] op);
    exp_t r;
    r.id  = id;
    r.ex  = 1'b0;
    r.err = 1'b0;
    r.z   = 32'h0;
    case (op)
      3'd0:    r.z = a & b;
      3'd1:    r.z = a | b;
      3'd2:    r.z = a + b;
      3'd6:    r.z = a - b;
      3'd7:    r.z = 32'h0;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] onehot(input bit id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // Monitor / reference model, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_z", bus.rsp_z, 32'h0);
        check("reset_rsp_ex", 32'(bus.rsp_ex), 32'h0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        m_busy = 1'b0;
        m_ptr  = 1'b0;
        sb.delete();
        cyc    = 0;
      end else begin
        bit         id;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        cyc++;
        id      = bus.req_valid[m_ptr] ? m_ptr : ~m_ptr;
        exp_rdy = (!m_busy && (bus.req_valid != 2'b00)) ? onehot(id) : 2'b00;
        exp_rv  = (m_busy && cyc >= m_due) ? onehot(m_id) : 2'b00;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (exp_rv != 2'b00 && sb.size() > 0) begin
          check("rsp_z", bus.rsp_z, sb[0].z);
          check("rsp_ex", 32'(bus.rsp_ex), 32'(sb[0].ex));
          check("rsp_err", 32'(bus.rsp_err), 32'(sb[0].err));
        end
        if (exp_rv != 2'b00 && bus.rsp_ready[m_id]) begin
          void'(sb.pop_front());
          m_busy = 1'b0;
        end else if (exp_rdy != 2'b00) begin
          exp_t e;
          e = id ? ref_op(id, bus.req1_a, bus.req1_b, bus.req1_op)
                 : ref_op(id, bus.req0_a, bus.req0_b, bus.req0_op);
          sb.push_back(e);
          m_busy = 1'b1;
          m_id   = id;
          m_ptr  = ~id;
          m_due  = cyc + (e.err ? 1 : int'(EC) + 1);
        end
      end
    end
  end

  task automatic set_req(input int i, input bit [31:0] a, input bit [31:0] b,
                         input bit [2:0] op);
    if (i == 0) begin
      bus.req0_a  = a;
      bus.req0_b  = b;
      bus.req0_op = op;
    end else begin
      bus.req1_a  = a;
      bus.req1_b  = b;
      bus.req1_op = op;
    end
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout req%0d: got no accept expected accept within 60 cycles", i);
    end
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk);
      #1;
      if (!m_busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'd0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Simple ADD on requester 0.
    set_req(0, 32'd5, 32'd3, 3'b010);
    wait_acc(0);
    wait_idle();

    // Both valid right after reset: requester 0 wins, then requester 1.
    do_reset();
    set_req(0, 32'd10, 32'd3, 3'b110);
    set_req(1, 32'hF0, 32'h3C, 3'b000);
    wait_acc(0);
    wait_acc(1);
    wait_idle();
    // Serve req0 alone, then both: pointer now favours req1.
    set_req(0, 32'd100, 32'd1, 3'b110);
    wait_acc(0);
    wait_idle();
    set_req(0, 32'h1234, 32'h4321, 3'b001);
    set_req(1, 32'd7, 32'd8, 3'b010);
    wait_acc(1);
    wait_acc(0);
    wait_idle();

    // Backpressure: only the non-owner signals ready while both requests wait.
    bus.rsp_ready = 2'b10;
    set_req(0, 32'd20, 32'd22, 3'b010);
    wait_acc(0);
    set_req(0, 32'hAAAA, 32'h5555, 3'b001);
    set_req(1, 32'hFF00, 32'h0FF0, 3'b000);
    repeat (8) @(posedge clk);
    #1;
    bus.rsp_ready = 2'b11;
    wait_acc(1);
    wait_acc(0);
    wait_idle();

    // Illegal op then a legal one on requester 1; plus other illegal codes and SLT.
    set_req(1, 32'd9, 32'd9, 3'b011);
    wait_acc(1);
    wait_idle();
    set_req(1, 32'd1, 32'd2, 3'b001);
    wait_acc(1);
    wait_idle();
    set_req(0, 32'd1, 32'd2, 3'b100);
    wait_acc(0);
    wait_idle();
    set_req(1, 32'd1, 32'd2, 3'b101);
    wait_acc(1);
    wait_idle();
    set_req(0, 32'd1, 32'd2, 3'b111);
    wait_acc(0);
    wait_idle();

    // Wrap-around ADD and OR.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b010);
    wait_acc(0);
    wait_idle();
    set_req(1, 32'h0F, 32'hF0, 3'b001);
    wait_acc(1);
    wait_idle();

    // Reset in the middle of EXEC: no response, pointer returns to requester 0.
    set_req(1, 32'd7, 32'd9, 3'b010);
    wait_acc(1);
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 32'd3, 32'd4, 3'b010);
    set_req(1, 32'd5, 32'd6, 3'b110);
    wait_acc(0);
    wait_acc(1);
    wait_idle();

    // Random traffic with random response backpressure.
    begin
      logic [1:0] acc;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
          if (acc[i]) bus.req_valid[i] = 1'b0;
          if (!bus.req_valid[i] && ($urandom % 3 == 0)) begin
            bit [31:0] a;
            bit [31:0] b;
            a = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom % 4 == 0) ? 32'd1 : $urandom;
            set_req(i, a, b, 3'($urandom % 8));
          end
        end
        bus.rsp_ready = 2'($urandom);
      end
    end

    // Drain.
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    wait_idle();
    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
